// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU sequencer.
package alu_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_AND = 2'b00;
  localparam opcode_t OP_OR  = 2'b01;
  localparam opcode_t OP_XOR = 2'b10;
  localparam opcode_t OP_ADD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: logic ops or full-adder sum with carry.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  opcode_t op,
  output logic    y,
  output logic    cout
);

  always_comb begin
    y    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: begin
        y    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU sequencer: streams operands LSB-first through one
// slice, rebuilding the result in a right-shifting register.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q,     state_next;
  logic [WIDTH-1:0] a_q,         a_next;
  logic [WIDTH-1:0] b_q,         b_next;
  opcode_t          op_q,        op_next;
  logic [WIDTH-1:0] shift_q,     shift_next;
  logic             carry_q,     carry_next;
  logic [CW-1:0]    cnt_q,       cnt_next;
  logic [WIDTH-1:0] result_next;
  logic             carry_out_next;
  logic             zero_next;
  logic             done_next;

  logic             slice_y;
  logic             slice_cout;
  logic [WIDTH-1:0] shifted;

  alu_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .y    (slice_y),
    .cout (slice_cout)
  );

  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign shifted = {slice_y, shift_q[WIDTH-1:1]};
  assign busy    = (state_q == RUN);

  always_comb begin
    state_next     = state_q;
    a_next         = a_q;
    b_next         = b_q;
    op_next        = op_q;
    shift_next     = shift_q;
    carry_next     = carry_q;
    cnt_next       = cnt_q;
    result_next    = result;
    carry_out_next = carry_out;
    zero_next      = zero;
    done_next      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          op_next    = op;
          shift_next = '0;
          carry_next = 1'b0;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      default: begin
        a_next     = a_q >> 1;
        b_next     = b_q >> 1;
        shift_next = shifted;
        carry_next = (op_q == OP_ADD) ? slice_cout : 1'b0;
        cnt_next   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          result_next    = shifted;
          carry_out_next = (op_q == OP_ADD) ? slice_cout : 1'b0;
          zero_next      = ~|shifted;
          done_next      = 1'b1;
          state_next     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      shift_q   <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_next;
      a_q       <= a_next;
      b_q       <= b_next;
      op_q      <= op_next;
      shift_q   <= shift_next;
      carry_q   <= carry_next;
      cnt_q     <= cnt_next;
      result    <= result_next;
      carry_out <= carry_out_next;
      zero      <= zero_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized self-checking bench for alu_serial_seq against an arithmetic model.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;

  int checks = 0;
  int failures = 0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} from plain arithmetic on the operands.
  function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'b00:   return {1'b0, x & y};
      2'b01:   return {1'b0, x | y};
      2'b10:   return {1'b0, x ^ y};
      default: return {1'b0, x} + {1'b0, y};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the accept edge pass.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_done", done, 1'b0);
  endtask

  // Wait for done (bounded), checking timing, stability and the final values.
  // Returns in the done cycle so the caller may issue back-to-back.
  task automatic finish_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           input bit junk);
    logic [W:0]   exp;
    logic [W-1:0] prev;
    int           k;
    exp  = model(o, x, y);
    prev = result;
    for (k = 1; k <= 20; k++) begin
      tick();
      if (junk && k == 3) begin
        a     = W'($urandom);
        b     = W'($urandom);
        op    = 2'($urandom);
        start = 1'b1;
      end
      if (junk && k == 4) start = 1'b0;
      if (done) break;
      chk("run_busy", busy, 1'b1);
      chk("run_result_stable", result, prev);
    end
    chk("latency", k, W);
    chk("result", result, exp[W-1:0]);
    chk("carry_out", carry_out, exp[W]);
    chk("zero", zero, (exp[W-1:0] == '0));
    chk("done_busy", busy, 1'b0);
    $display("op=%0d a=%02h b=%02h -> result=%02h carry=%0b zero=%0b latency=%0d",
             o, x, y, result, carry_out, zero, k);
  endtask

  task automatic expect_done_low();
    tick();
    chk("done_single", done, 1'b0);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_carry", carry_out, 1'b0);
    chk("rst_zero", zero, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
    end

    launch(2'b11, 8'hFF, 8'h01);
    finish_op(2'b11, 8'hFF, 8'h01, 1'b0);
    expect_done_low();

    launch(2'b00, 8'hF0, 8'h3C);
    finish_op(2'b00, 8'hF0, 8'h3C, 1'b0);
    expect_done_low();

    launch(2'b01, 8'hA0, 8'h05);
    finish_op(2'b01, 8'hA0, 8'h05, 1'b0);
    expect_done_low();

    launch(2'b10, 8'hAA, 8'hFF);
    finish_op(2'b10, 8'hAA, 8'hFF, 1'b1);
    expect_done_low();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("no_extra_done", done, 1'b0);
      chk("no_extra_busy", busy, 1'b0);
    end

    // Abort mid-operation with reset; result from the XOR must be wiped.
    launch(2'b11, 8'h3C, 8'h0F);
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, '0);
    chk("abort_done", done, 1'b0);
    chk("abort_carry", carry_out, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_done", done, 1'b0);
    end
    launch(2'b11, 8'h12, 8'h34);
    finish_op(2'b11, 8'h12, 8'h34, 1'b0);
    expect_done_low();

    // Back-to-back: second start held during the done cycle.
    launch(2'b11, 8'h80, 8'h80);
    finish_op(2'b11, 8'h80, 8'h80, 1'b0);
    launch(2'b10, 8'h0F, 8'h01);
    finish_op(2'b10, 8'h0F, 8'h01, 1'b0);
    expect_done_low();

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 7 == 0) rb = ~ra;
      if (i % 11 == 0) rb = ra;
      launch(ro, ra, rb);
      finish_op(ro, ra, rb, (i % 5 == 0));
      if ($urandom_range(0, 1) == 0) expect_done_low();
    end
    expect_done_low();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial N-bit ALU sequencer sitting directly upstream of the 1-bit ALU datapath. It accepts a WIDTH-bit operand pair and a 2-bit opcode, then feeds the operands through a single 1-bit slice LSB-first, one bit per clock. It accumulates the result bits and the ripple carry between cycles, and presents a WIDTH-bit result with carry and zero flags on completion.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only while busy=0.
- op  input  2  opcode: 00 AND, 01 OR, 10 XOR, 11 ADD; latched on accept.
- a  input  WIDTH  operand A; latched on accept.
- b  input  WIDTH  operand B; latched on accept.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  final result; held until the next completion.
- carry_out  output  1  final carry for ADD; 0 for AND/OR/XOR.
- zero  output  1  high when result == 0; held with result.

## Operation
- States: IDLE, RUN.
- Reset (async, rst_n=0):
  - State IDLE; busy=0, done=0, result=0, carry_out=0, zero=0.
  - Internal operand, shift, carry and bit-counter registers cleared.
- IDLE with start=1:
  - Latch a, b and op.
  - Clear carry and bit counter (cnt=0).
  - Move to RUN.
- RUN, each cycle:
  - Slice inputs: a_q[0], b_q[0], carry_q, op_q.
  - Shift a_q and b_q right by 1.
  - Shift the slice output into the MSB of the internal shift register, moving existing bits right.
  - ADD updates carry_q from the slice cout.
  - AND/OR/XOR hold carry_q at 0.
  - cnt increments each cycle.
- RUN, cnt == WIDTH-1 (last bit):
  - Copy the completed shift value to result.
  - Set carry_out to the final carry (0 if op is not ADD).
  - Set zero to the reduction-NOR of the completed value.
  - Pulse done; return to IDLE.
- ADD arithmetic:
  - Modulo 2^WIDTH; overflow is reported only via carry_out.
  - No signed interpretation.
- start while busy=1 is ignored; operand and op changes during RUN have no effect.
- Reset mid-operation aborts immediately. The partial result is discarded, result is cleared, and done is not pulsed.

## Timing
- Accept edge T0 (IDLE, start=1): busy=1 from T0.
- Bit i is processed on edge T(i+1), for i = 0..WIDTH-1.
- Edge T(WIDTH): result, carry_out and zero update; done=1 and busy=0 for the following cycle.
- done is high exactly one cycle; it falls at T(WIDTH+1) unless a new operation completes.
- Back-to-back:
  - start held high during the done cycle is accepted at T(WIDTH+1).
  - Minimum issue period is WIDTH+1 cycles.
- Latency from accept edge to done-high is WIDTH cycles.
- result, carry_out and zero change only at completion or reset; they are stable during RUN.

## Structure
- Shared package alu_pkg:
  - opcode typedef (2-bit);
  - constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ADD=2'b11;
  - state encoding IDLE/RUN.
- Sub-module alu_bit_slice: combinational; inputs a, b, cin, op; outputs y, cout.
  - y is AND/OR/XOR, or the sum bit a^b^cin for ADD.
  - cout is the ADD carry, 0 otherwise.
- Bit counter width: $clog2(WIDTH).

## Test plan
- Reset then idle:
  - all outputs 0;
  - start=0 for 20 cycles -> busy, done stay 0.
- ADD, WIDTH=8, a=8'hFF, b=8'h01:
  - start at T0 -> done at T8;
  - result=8'h00, carry_out=1, zero=1;
  - busy high T0..T8.
- AND 8'hF0 & 8'h3C -> result=8'h30, carry_out=0, zero=0. OR 8'hA0 | 8'h05 -> result=8'hA5.
- XOR 8'hAA ^ 8'hFF -> result=8'h55. Change a/b/op and pulse start mid-RUN -> result still 8'h55, single done.
- ADD 8'h3C + 8'h0F (expected 8'h4B):
  - drop rst_n at T4 -> busy=0, result=0 immediately, no done;
  - after release, ADD 8'h12+8'h34 -> result 8'h46.
- Back-to-back:
  - ADD 8'h80+8'h80 (result 8'h00, carry 1, zero 1);
  - start high in done cycle with XOR 8'h0F^8'h01 -> accepted at T9;
  - second done at T17 with result 8'h0E, carry_out 0, zero 0.
